// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types and constants: widths, reset PC, FSM encoding,
// queue entry layout and PC alignment helper.
package inst_fetch_pkg;
   localparam int          XLEN         = 64;
   localparam int          INST_W       = 32;
   localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fq_entry_t;

   function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response port plus the
// decode-side valid/ready queue head.
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic              imem_req;
   logic [XLEN-1:0]   imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [INST_W-1:0] imem_rdata;
   logic              id_valid;
   logic              id_ready;
   logic [XLEN-1:0]   id_pc;
   logic [INST_W-1:0] id_inst;

   modport master (
      output imem_req, imem_addr,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output id_valid, id_pc, id_inst,
      input  id_ready
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  id_valid, id_pc, id_inst,
      output id_ready
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Two-entry {pc,inst} FIFO between fetch and decode; flush wins over any
// simultaneous push/pop.
module fetch_queue
   import inst_fetch_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  logic      flush,
   input  fq_entry_t wr_entry,
   output fq_entry_t head,
   output logic [1:0] count
);
   fq_entry_t mem [2];
   logic      rd_ptr;
   logic      wr_ptr;
   logic      do_pop;

   assign do_pop = pop && (count != 2'd0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         case ({push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the fetch PC, issues one outstanding imem request at a
// time, queues responses toward decode and applies EX redirects.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            br_e,
   input  logic [XLEN-1:0] br_addr,
   inst_fetch_if.master    bus
);
   fetch_state_t    state;
   fetch_state_t    state_nx;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] req_pc_q;
   logic            drop_q;
   logic            req;
   logic            granted;
   logic            redirect;
   logic            push;
   logic            pop;
   logic            flush;
   logic [1:0]      count;
   logic [1:0]      cnt_after;
   fq_entry_t       wr_entry;
   fq_entry_t       head;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   // A redirect forces cnt_after to 0, so WAIT/HOLD return to REQ without a separate branch.
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: state_nx = ST_REQ;
         ST_REQ:  if (bus.imem_gnt) state_nx = ST_WAIT;
         ST_WAIT: if (bus.imem_rvalid) state_nx = (cnt_after < 2'd2) ? ST_REQ : ST_HOLD;
         ST_HOLD: if (cnt_after < 2'd2) state_nx = ST_REQ;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      req      = (state == ST_REQ);
      redirect = br_e && (state != ST_IDLE);
      flush    = redirect;
      push     = (state == ST_WAIT) && bus.imem_rvalid && !drop_q && !br_e;
   end

   assign granted = req && bus.imem_gnt;
   assign pop     = bus.id_valid && bus.id_ready;

   always_comb begin
      cnt_after = count;
      if (flush)
         cnt_after = 2'd0;
      else if (push && !pop)
         cnt_after = count + 2'd1;
      else if (!push && pop)
         cnt_after = count - 2'd1;
   end

   // drop_q marks the single outstanding response as stale after a redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         req_pc_q <= RESET_PC;
         drop_q   <= 1'b0;
      end else begin
         if (redirect)
            pc_q <= align_pc(br_addr);
         else if (granted)
            pc_q <= pc_q + XLEN'(4);
         if (granted)
            req_pc_q <= pc_q;
         case (state)
            ST_REQ:  if (granted && br_e) drop_q <= 1'b1;
            ST_WAIT: begin
               if (bus.imem_rvalid)
                  drop_q <= 1'b0;
               else if (br_e)
                  drop_q <= 1'b1;
            end
            default: drop_q <= drop_q;
         endcase
      end
   end

   assign wr_entry = '{pc: req_pc_q, inst: bus.imem_rdata};

   fetch_queue u_queue (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .flush    (flush),
      .wr_entry (wr_entry),
      .head     (head),
      .count    (count)
   );

   assign bus.imem_req  = req;
   assign bus.imem_addr = align_pc(pc_q);
   assign bus.id_valid  = (count != 2'd0);
   assign bus.id_pc     = head.pc;
   assign bus.id_inst   = head.inst;
endmodule
